l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single L1-side port of the L2 cache between the I-side L1 (port 0)
//  and the D-side L1 (port 1). Grants one request, holds its address/data/strobes stable toward L2,
//  and returns the L2 data/hit to the granted requester only. Sits between the two L1 caches and L2_cache.
// PARAMETERS
//  DATA_WIDTH      32   data bus width, all ports
//  ADDR_WIDTH      32   address bus width, all ports
//  TIMEOUT_CYCLES  255  max cycles waiting for l2_ready before abort; 0 = watchdog disabled; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk           in   1           clock, all logic on posedge
//  rst_n         in   1           synchronous active-low reset
//  r0_addr       in   ADDR_WIDTH  port 0 (I-side) address
//  r0_data_in    in   DATA_WIDTH  port 0 write data
//  r0_read       in   1           port 0 read request (level, held until r0_ready)
//  r0_write      in   1           port 0 write request (level, held until r0_ready)
//  r0_data_out   out  DATA_WIDTH  port 0 read data, valid with r0_ready
//  r0_ready      out  1           port 0 completion, 1-cycle pulse
//  r0_hit        out  1           port 0 L2 hit flag, valid with r0_ready
//  r1_*          -    -           identical port 1 (D-side) set: r1_addr, r1_data_in, r1_read, r1_write, r1_data_out, r1_ready, r1_hit
//  l2_addr       out  ADDR_WIDTH  to L2 l1_cache_addr
//  l2_data_out   out  DATA_WIDTH  to L2 l1_cache_data_in
//  l2_read       out  1           to L2 l1_cache_read
//  l2_write      out  1           to L2 l1_cache_write
//  l2_data_in    in   DATA_WIDTH  from L2 l1_cache_data_out
//  l2_ready      in   1           from L2 l1_cache_ready
//  l2_hit        in   1           from L2 l1_cache_hit
//  arb_timeout   out  1           1-cycle pulse when watchdog aborts a transaction
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state IDLE, all outputs 0, last_grant=1 (port 0 wins first tie), watchdog=0.
//    Reset mid-transaction abandons it; no ready pulse is issued.
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE.
//    IDLE: req_n = rn_read|rn_write. If any req, select winner, latch addr/data/op into grant regs, go ISSUE.
//    ISSUE: drive l2_addr/l2_data_out/l2_read|l2_write from grant regs, constant until exit.
//      On l2_ready: capture l2_data_in/l2_hit, drop l2 strobes, go RESP.
//      On watchdog expiry: drop strobes, pulse arb_timeout, go RESP with data=0, hit=0.
//    RESP: winner's rN_ready=1, rN_data_out/rN_hit=captured values for exactly this cycle; loser's outputs stay 0.
//      Update last_grant; go IDLE.
//  - Latency: request sampled in IDLE at edge N -> l2 strobe high after edge N+1.
//    l2_ready sampled at edge M -> rN_ready high after edge M+1. Minimum 3 cycles request to ready.
//  - Requesters must deassert read/write in the cycle they sample rN_ready. Requests arriving during ISSUE/RESP
//    wait. A loser's request is never dropped.
//  - read and write both high on one port: treated as write.
//  - Requester inputs are not re-sampled after the grant; changes during ISSUE are ignored.
//  - Watchdog counts ISSUE cycles; expires when count == TIMEOUT_CYCLES. Cleared on entering ISSUE.
//  - l2_ready outside ISSUE is ignored.
//  - rN_data_out after a write is don't-care but deterministic: captured l2_data_in.
// CONFIGURATION
//  L2_ARB_RR_EN defined: round-robin on tie; winner = port != last_grant.
//    Single requester always wins.
//  L2_ARB_RR_EN undefined: fixed priority, port 1 (D-side) always wins ties; last_grant still tracked but unused.
// TESTING
//  1. r0_read addr=0x100, L2 returns l2_ready 2 cycles after strobe, data=0xDEADBEEF, hit=1 ->
//     l2_addr=0x100, l2_read=1 until ready; r0_ready pulse with data 0xDEADBEEF, hit=1; r1_ready=0.
//  2. r1_write addr=0x200 data=0x12345678 -> l2_write=1, l2_data_out=0x12345678; r1_ready single pulse, no l2_read.
//  3. r0_read and r1_read in same cycle, both held -> RR: port 0 first then port 1; fixed: port 1 first then port 0.
//     Both complete, no third L2 access.
//  4. Continuous r0 and r1 requests for 6 transactions -> RR grants alternate 0,1,0,1,0,1.
//  5. TIMEOUT_CYCLES=4, l2_ready held 0 -> arb_timeout pulses 4 ISSUE cycles after strobe;
//     r0_ready with data=0, hit=0; state back to IDLE.
//  6. rst_n low one cycle during ISSUE -> next cycle all outputs 0, no rN_ready pulse; new request serviced normally.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ----------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares the single L1-side port of the L2 cache between the I-side L1
// (port 0) and the D-side L1 (port 1). One request is granted at a time. Its
// address, write data and operation are latched and held stable toward L2
// until L2 answers or the watchdog gives up. The L2 read data and hit flag are
// returned only to the granted port, as a one-cycle ready pulse.
//
// Configuration macro: L2_ARB_RR_EN
//   defined   : round-robin tie break (the port that was not granted last wins)
//   undefined : fixed priority, port 1 (D-side) wins every tie
//
// Parameters
//   DATA_WIDTH      data bus width on all ports
//   ADDR_WIDTH      address bus width on all ports
//   TIMEOUT_CYCLES  ISSUE cycles to wait for l2_ready before aborting (0 = off)
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   rN_addr/rN_data_in          requester N address / write data
//   rN_read/rN_write            requester N level request, held until rN_ready
//   rN_data_out/rN_hit/rN_ready requester N response, valid with rN_ready pulse
//   l2_addr/l2_data_out         address / write data toward L2
//   l2_read/l2_write            operation strobes toward L2
//   l2_data_in/l2_hit/l2_ready  response from L2
//   arb_timeout                 one-cycle pulse when the watchdog aborts
//
// Timing: a request sampled in IDLE at edge N raises the L2 strobe after
// edge N+1; l2_ready sampled at edge M raises rN_ready after edge M+1.
// ----------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_data_in,
    input  logic                  r0_read,
    input  logic                  r0_write,
    output logic [DATA_WIDTH-1:0] r0_data_out,
    output logic                  r0_ready,
    output logic                  r0_hit,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_data_in,
    input  logic                  r1_read,
    input  logic                  r1_write,
    output logic [DATA_WIDTH-1:0] r1_data_out,
    output logic                  r1_ready,
    output logic                  r1_hit,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0] l2_data_out,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [DATA_WIDTH-1:0] l2_data_in,
    input  logic                  l2_ready,
    input  logic                  l2_hit,
    output logic                  arb_timeout
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_ONE   = CNT_W'(1);
    localparam logic            WDOG_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Grant registers: snapshot of the winning request, held for the whole transaction
    logic                  r_gnt_port;
    logic [ADDR_WIDTH-1:0] r_gnt_addr;
    logic [DATA_WIDTH-1:0] r_gnt_data;
    logic                  r_gnt_write;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_wdog;
    logic [DATA_WIDTH-1:0] r_cap_data;
    logic                  r_cap_hit;

    // Registered outputs
    logic [ADDR_WIDTH-1:0] r_l2_addr;
    logic [DATA_WIDTH-1:0] r_l2_data_out;
    logic                  r_l2_read;
    logic                  r_l2_write;
    logic                  r_arb_timeout;
    logic [DATA_WIDTH-1:0] r_r0_data_out;
    logic                  r_r0_ready;
    logic                  r_r0_hit;
    logic [DATA_WIDTH-1:0] r_r1_data_out;
    logic                  r_r1_ready;
    logic                  r_r1_hit;

    // Combinational arbitration / handshake terms
    logic                  w_req0;
    logic                  w_req1;
    logic                  w_any_req;
    logic                  w_tie_port;
    logic                  w_win_port;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_win_write;
    logic                  w_in_issue;
    logic                  w_l2_ack;
    logic                  w_wdog_exp;
    logic                  w_issue_exit;

`ifdef L2_ARB_RR_EN
    // Round-robin: on a tie the port that was not served last goes first.
    assign w_tie_port = ~r_last_grant;
`else
    // Fixed priority: the D-side port always wins a tie. The grant history is
    // still kept but has no influence on the result here.
    assign w_tie_port = r_last_grant | 1'b1;
`endif

    // Request qualification and winner selection.
    always_comb begin
        // A port whose ready pulse is on the wire right now is still holding its
        // request for this one cycle; it must not be granted a second time.
        w_req0    = (r0_read | r0_write) & ~r_r0_ready;
        w_req1    = (r1_read | r1_write) & ~r_r1_ready;
        w_any_req = w_req0 | w_req1;

        if (w_req0 && w_req1) begin
            w_win_port = w_tie_port;
        end else if (w_req1) begin
            w_win_port = 1'b1;
        end else begin
            w_win_port = 1'b0;
        end

        // read and write together on one port resolve to a write
        if (w_win_port) begin
            w_win_addr  = r1_addr;
            w_win_data  = r1_data_in;
            w_win_write = r1_write;
        end else begin
            w_win_addr  = r0_addr;
            w_win_data  = r0_data_in;
            w_win_write = r0_write;
        end
    end

    // ISSUE exit conditions: L2 answer (only once the strobe is visible) or watchdog.
    always_comb begin
        w_in_issue   = (r_state == ST_ISSUE);
        w_l2_ack     = w_in_issue && (r_l2_read || r_l2_write) && l2_ready;
        w_wdog_exp   = WDOG_EN && w_in_issue && !w_l2_ack && (r_wdog == WDOG_LIMIT);
        w_issue_exit = w_l2_ack || w_wdog_exp;
    end

    // Next-state logic for IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_issue_exit) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant latch, watchdog counter, response capture and grant history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt_port   <= 1'b0;
            r_gnt_addr   <= '0;
            r_gnt_data   <= '0;
            r_gnt_write  <= 1'b0;
            r_last_grant <= 1'b1;
            r_wdog       <= '0;
            r_cap_data   <= '0;
            r_cap_hit    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_gnt_port  <= w_win_port;
                r_gnt_addr  <= w_win_addr;
                r_gnt_data  <= w_win_data;
                r_gnt_write <= w_win_write;
                r_wdog      <= '0;
            end else if (w_in_issue && !w_issue_exit) begin
                r_wdog <= r_wdog + WDOG_ONE;
            end else begin
                r_wdog <= r_wdog;
            end

            // An aborted transaction returns zero data and a miss.
            if (w_l2_ack) begin
                r_cap_data <= l2_data_in;
                r_cap_hit  <= l2_hit;
            end else if (w_wdog_exp) begin
                r_cap_data <= '0;
                r_cap_hit  <= 1'b0;
            end else begin
                r_cap_data <= r_cap_data;
                r_cap_hit  <= r_cap_hit;
            end

            if (r_state == ST_RESP) begin
                r_last_grant <= r_gnt_port;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Registered outputs: L2 strobes during ISSUE, requester response during RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l2_addr     <= '0;
            r_l2_data_out <= '0;
            r_l2_read     <= 1'b0;
            r_l2_write    <= 1'b0;
            r_arb_timeout <= 1'b0;
            r_r0_data_out <= '0;
            r_r0_ready    <= 1'b0;
            r_r0_hit      <= 1'b0;
            r_r1_data_out <= '0;
            r_r1_ready    <= 1'b0;
            r_r1_hit      <= 1'b0;
        end else begin
            if (w_in_issue && !w_issue_exit) begin
                r_l2_addr     <= r_gnt_addr;
                r_l2_data_out <= r_gnt_data;
                r_l2_read     <= ~r_gnt_write;
                r_l2_write    <= r_gnt_write;
            end else begin
                r_l2_addr     <= '0;
                r_l2_data_out <= '0;
                r_l2_read     <= 1'b0;
                r_l2_write    <= 1'b0;
            end

            r_arb_timeout <= w_wdog_exp;

            if ((r_state == ST_RESP) && !r_gnt_port) begin
                r_r0_ready    <= 1'b1;
                r_r0_data_out <= r_cap_data;
                r_r0_hit      <= r_cap_hit;
            end else begin
                r_r0_ready    <= 1'b0;
                r_r0_data_out <= '0;
                r_r0_hit      <= 1'b0;
            end

            if ((r_state == ST_RESP) && r_gnt_port) begin
                r_r1_ready    <= 1'b1;
                r_r1_data_out <= r_cap_data;
                r_r1_hit      <= r_cap_hit;
            end else begin
                r_r1_ready    <= 1'b0;
                r_r1_data_out <= '0;
                r_r1_hit      <= 1'b0;
            end
        end
    end

    assign l2_addr     = r_l2_addr;
    assign l2_data_out = r_l2_data_out;
    assign l2_read     = r_l2_read;
    assign l2_write    = r_l2_write;
    assign arb_timeout = r_arb_timeout;
    assign r0_data_out = r_r0_data_out;
    assign r0_ready    = r_r0_ready;
    assign r0_hit      = r_r0_hit;
    assign r1_data_out = r_r1_data_out;
    assign r1_ready    = r_r1_ready;
    assign r1_hit      = r_r1_hit;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter. Stimulus pushes the expected L2 access
// (in expected grant order) and the expected requester response; an L2 model
// checks each access it sees, and a monitor checks every ready / timeout pulse.
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_data_in, r1_data_in;
    logic          r0_read, r0_write, r1_read, r1_write;
    logic [DW-1:0] r0_data_out, r1_data_out;
    logic          r0_ready, r0_hit, r1_ready, r1_hit;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_data_out;
    logic          l2_read, l2_write;
    logic [DW-1:0] l2_data_in;
    logic          l2_ready, l2_hit;
    logic          arb_timeout;

    always #5 clk = ~clk;

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r0_addr), .r0_data_in(r0_data_in), .r0_read(r0_read), .r0_write(r0_write),
        .r0_data_out(r0_data_out), .r0_ready(r0_ready), .r0_hit(r0_hit),
        .r1_addr(r1_addr), .r1_data_in(r1_data_in), .r1_read(r1_read), .r1_write(r1_write),
        .r1_data_out(r1_data_out), .r1_ready(r1_ready), .r1_hit(r1_hit),
        .l2_addr(l2_addr), .l2_data_out(l2_data_out), .l2_read(l2_read), .l2_write(l2_write),
        .l2_data_in(l2_data_in), .l2_ready(l2_ready), .l2_hit(l2_hit),
        .arb_timeout(arb_timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        hit;
        logic        stall;
    } l2_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } rsp_t;

    l2_exp_t l2_q[$];
    rsp_t    rsp_q0[$];
    rsp_t    rsp_q1[$];
    int      to_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    // Queue one expected transaction: the L2 access and the requester response.
    task automatic exp_txn(input int p, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input logic hit, input logic stall);
        l2_exp_t e;
        rsp_t    r;
        e.addr = addr; e.wr = wr; e.wdata = wd; e.rdata = rd; e.hit = hit; e.stall = stall;
        l2_q.push_back(e);
        r.data = stall ? 32'h0 : rd;
        r.hit  = stall ? 1'b0 : hit;
        if (p == 0) rsp_q0.push_back(r);
        else        rsp_q1.push_back(r);
        if (stall) to_q.push_back(TO);
    endtask

    // Requester: op 0 = read, 1 = write, 2 = read and write together.
    task automatic do_txn(input int p, input int op, input logic [31:0] addr, input logic [31:0] wd);
        bit done;
        @(posedge clk); #1;
        if (p == 0) begin
            r0_addr = addr; r0_data_in = wd; r0_read = (op != 1); r0_write = (op != 0);
        end else begin
            r1_addr = addr; r1_data_in = wd; r1_read = (op != 1); r1_write = (op != 0);
        end
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((p == 0) ? r0_ready : r1_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL r%0d_ready_wait: no ready within 60 cycles for addr 0x%08h", p, addr);
        end
        @(posedge clk); #1;
        if (p == 0) begin r0_read = 1'b0; r0_write = 1'b0; end
        else        begin r1_read = 1'b0; r1_write = 1'b0; end
    endtask

    // L2 model: checks each access against the head of l2_q, answers 2 cycles after the strobe.
    initial begin : l2_model
        l2_exp_t e;
        l2_ready = 1'b0; l2_data_in = '0; l2_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (l2_read || l2_write)) begin
                if (l2_q.size() == 0) begin
                    unexpected("l2_extra_access");
                end else begin
                    e = l2_q.pop_front();
                    chk("l2_addr", l2_addr, e.addr);
                    chk("l2_write", {31'd0, l2_write}, {31'd0, e.wr});
                    chk("l2_read", {31'd0, l2_read}, {31'd0, ~e.wr});
                    if (e.wr) chk("l2_wdata", l2_data_out, e.wdata);
                    if (!e.stall) begin
                        repeat (2) @(posedge clk);
                        #1 l2_ready = 1'b1; l2_data_in = e.rdata; l2_hit = e.hit;
                        @(posedge clk);
                        #1 l2_ready = 1'b0; l2_data_in = '0; l2_hit = 1'b0;
                    end
                end
                for (int k = 0; k < 40; k++) begin
                    if (!(l2_read || l2_write)) break;
                    @(negedge clk);
                end
                chk("l2_strobe_drop", {31'd0, l2_read | l2_write}, 32'd0);
            end
        end
    end

    // Monitor: pops the expected response whenever a ready or timeout pulse appears.
    initial begin : monitor
        int   strobe_cycles;
        logic prev_strobe;
        rsp_t r;
        strobe_cycles = 0;
        prev_strobe   = 1'b0;
        forever begin
            @(negedge clk);
            if (l2_read || l2_write) strobe_cycles = prev_strobe ? strobe_cycles + 1 : 1;
            prev_strobe = l2_read || l2_write;
            if (r0_ready) begin
                chk("r1_quiet_during_r0", {r1_ready, r1_hit, 30'd0} | r1_data_out, 32'd0);
                if (rsp_q0.size() == 0) begin
                    unexpected("r0_ready");
                end else begin
                    r = rsp_q0.pop_front();
                    chk("r0_data_out", r0_data_out, r.data);
                    chk("r0_hit", {31'd0, r0_hit}, {31'd0, r.hit});
                end
            end
            if (r1_ready) begin
                chk("r0_quiet_during_r1", {r0_ready, r0_hit, 30'd0} | r0_data_out, 32'd0);
                if (rsp_q1.size() == 0) begin
                    unexpected("r1_ready");
                end else begin
                    r = rsp_q1.pop_front();
                    chk("r1_data_out", r1_data_out, r.data);
                    chk("r1_hit", {31'd0, r1_hit}, {31'd0, r.hit});
                end
            end
            if (arb_timeout) begin
                if (to_q.size() == 0) unexpected("arb_timeout");
                else chk("timeout_latency", strobe_cycles, to_q.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_l2_strobes"}, {30'd0, l2_read, l2_write}, 32'd0);
        chk({name, "_l2_addr"}, l2_addr, 32'd0);
        chk({name, "_l2_data_out"}, l2_data_out, 32'd0);
        chk({name, "_readys"}, {29'd0, r0_ready, r1_ready, arb_timeout}, 32'd0);
        chk({name, "_rdata"}, r0_data_out | r1_data_out, 32'd0);
        chk({name, "_hits"}, {30'd0, r0_hit, r1_hit}, 32'd0);
    endtask

    initial begin : stimulus
        bit seen;
        int p;
        rst_n = 1'b0;
        r0_addr = '0; r0_data_in = '0; r0_read = 1'b0; r0_write = 1'b0;
        r1_addr = '0; r1_data_in = '0; r1_read = 1'b0; r1_write = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        // 1: port 0 read, hit
        exp_txn(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        do_txn(0, 0, 32'h100, 32'h0);
        // 2: port 1 write
        exp_txn(1, 1'b1, 32'h200, 32'h12345678, 32'h0BADF00D, 1'b0, 1'b0);
        do_txn(1, 1, 32'h200, 32'h12345678);
        // read and write both high resolves to a write
        exp_txn(1, 1'b1, 32'h240, 32'hCAFE0001, 32'h00000240, 1'b1, 1'b0);
        do_txn(1, 2, 32'h240, 32'hCAFE0001);

        // 3: simultaneous reads (last grant was port 1)
`ifdef L2_ARB_RR_EN
        exp_txn(0, 1'b0, 32'h300, 32'h0, 32'h33330000, 1'b1, 1'b0);
        exp_txn(1, 1'b0, 32'h304, 32'h0, 32'h33330004, 1'b0, 1'b0);
`else
        exp_txn(1, 1'b0, 32'h304, 32'h0, 32'h33330004, 1'b0, 1'b0);
        exp_txn(0, 1'b0, 32'h300, 32'h0, 32'h33330000, 1'b1, 1'b0);
`endif
        fork
            do_txn(0, 0, 32'h300, 32'h0);
            do_txn(1, 0, 32'h304, 32'h0);
        join

        // 4: continuous traffic from both ports, six grants alternate
        for (int i = 0; i < 6; i++) begin
`ifdef L2_ARB_RR_EN
            p = i % 2;
`else
            p = 1 - (i % 2);
`endif
            exp_txn(p, 1'b0, 32'h1000 * (p + 1) + 32'(4 * (i / 2)), 32'h0,
                    (32'h1000 * (p + 1) + 32'(4 * (i / 2))) ^ 32'hA5A50000, 1'((i / 2) % 2), 1'b0);
        end
        fork
            for (int k = 0; k < 3; k++) do_txn(0, 0, 32'h1000 + 32'(4 * k), 32'h0);
            for (int k = 0; k < 3; k++) do_txn(1, 0, 32'h2000 + 32'(4 * k), 32'h0);
        join

        // 5: L2 never answers -> watchdog abort
        exp_txn(0, 1'b0, 32'h500, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
        do_txn(0, 0, 32'h500, 32'h0);
        @(negedge clk);
        chk("after_timeout_idle", {30'd0, l2_read | l2_write, arb_timeout}, 32'd0);

        // 6: reset while in ISSUE abandons the transaction
        begin
            l2_exp_t e;
            e.addr = 32'h600; e.wr = 1'b0; e.wdata = 32'h0; e.rdata = 32'h0; e.hit = 1'b0; e.stall = 1'b1;
            l2_q.push_back(e);
        end
        @(posedge clk); #1;
        r0_addr = 32'h600; r0_read = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (l2_read) begin seen = 1'b1; break; end
        end
        chk("t6_strobe_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; r0_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_reset_quiet", {29'd0, r0_ready, r1_ready, arb_timeout}, 32'd0);
        end
        exp_txn(1, 1'b0, 32'h700, 32'h0, 32'h77777777, 1'b1, 1'b0);
        do_txn(1, 0, 32'h700, 32'h0);
        exp_txn(0, 1'b1, 32'h704, 32'h5A5A5A5A, 32'h00000704, 1'b0, 1'b0);
        do_txn(0, 1, 32'h704, 32'h5A5A5A5A);

        repeat (5) @(posedge clk);
        chk("l2_queue_drained", l2_q.size(), 32'd0);
        chk("r0_queue_drained", rsp_q0.size(), 32'd0);
        chk("r1_queue_drained", rsp_q1.size(), 32'd0);
        chk("timeout_queue_drained", to_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : global_bound
        #200000;
        $display("FAIL global_time_bound: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "time bound expired");
    end

endmodule
